// File: rtl/rv32_pkg.sv
// Shared RV32I load/store encodings and LSU state definitions.
package rv32_pkg;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // LSU controller states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT_R = 2'd2,
        ST_DONE   = 2'd3
    } lsu_state_e;

    // Access width classes
    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_e;

    // Width of an access; any funct3 that is not a listed byte/half code is a word.
    function automatic acc_size_e access_size(input logic [2:0] f3, input logic store);
        acc_size_e sz;
        sz = SZ_WORD;
        if (store) begin
            case (f3)
                F3_SB:   sz = SZ_BYTE;
                F3_SH:   sz = SZ_HALF;
                default: sz = SZ_WORD;
            endcase
        end else begin
            case (f3)
                F3_LB, F3_LBU: sz = SZ_BYTE;
                F3_LH, F3_LHU: sz = SZ_HALF;
                default:       sz = SZ_WORD;
            endcase
        end
        return sz;
    endfunction

    // True when the byte offset does not respect the natural alignment of the width.
    function automatic logic is_misaligned(input acc_size_e sz, input logic [1:0] off);
        logic bad;
        case (sz)
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_lane_align.sv
// Byte-lane steering: store byte enables / replicated data, load shift and extension.
module lsu_lane_align (
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_offset,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_offset,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_result
);
    import rv32_pkg::*;

    logic [31:0] shifted;

    // Store path: pick enabled lanes and replicate data across the word.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = st_data;
        case (access_size(st_funct3, 1'b1))
            SZ_BYTE: begin
                st_be    = 4'b0001 << st_offset;
                st_wdata = {4{st_data[7:0]}};
            end
            SZ_HALF: begin
                st_be    = st_offset[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{st_data[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = st_data;
            end
        endcase
    end

    // Load path: move the addressed lane to bit 0, then sign/zero extend.
    always_comb begin
        shifted = ld_rdata >> {ld_offset, 3'b000};
        case (ld_funct3)
            F3_LB:   ld_result = {{24{shifted[7]}}, shifted[7:0]};
            F3_LBU:  ld_result = {24'h000000, shifted[7:0]};
            F3_LH:   ld_result = {{16{shifted[15]}}, shifted[15:0]};
            F3_LHU:  ld_result = {16'h0000, shifted[15:0]};
            default: ld_result = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit between the MEM stage and a handshaked data RAM.
//
// Memory handshake: mem_req is held high from the cycle after acceptance
// of an op until the first cycle in which mem_gnt is sampled high; that
// cycle transfers mem_addr/mem_we/mem_be/mem_wdata. For reads, mem_rvalid
// qualifies mem_rdata, in the grant cycle or any later cycle. mem_gnt and
// mem_rvalid are ignored whenever no transfer or read is outstanding.
module lsu_mem_ctrl #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        ex_read,
    input  logic        ex_write,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    output logic        stall,
    output logic [31:0] ld_data,
    output logic        ld_valid,
    output logic        misalign,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  dbg_state
);
    import rv32_pkg::*;

    lsu_state_e  state;
    logic [2:0]  funct3_q;
    logic [1:0]  offset_q;
    logic [31:0] tcnt;

    logic        op;
    acc_size_e   ex_size;
    logic        timeout_hit;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] ld_ext;

    assign op        = ex_valid & (ex_read | ex_write);
    assign ex_size   = access_size(ex_funct3, ex_write);
    assign misalign  = ~reset & op & (state == ST_IDLE) & is_misaligned(ex_size, ex_addr[1:0]);
    // The pipeline is released in DONE; reset forces it free immediately.
    assign stall     = ~reset & op & ~misalign & (state != ST_DONE);
    assign dbg_state = state;

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tcnt == 32'(TIMEOUT_CYCLES - 1));

    lsu_lane_align u_lane (
        .st_funct3 (ex_funct3),
        .st_offset (ex_addr[1:0]),
        .st_data   (ex_wdata),
        .st_be     (st_be),
        .st_wdata  (st_wdata),
        .ld_funct3 (funct3_q),
        .ld_offset (offset_q),
        .ld_rdata  (mem_rdata),
        .ld_result (ld_ext)
    );

    // Access FSM with registered memory-side outputs, load result and timeout counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            funct3_q  <= 3'b000;
            offset_q  <= 2'b00;
            tcnt      <= 32'd0;
            ld_data   <= 32'd0;
            ld_valid  <= 1'b0;
            bus_err   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'b0000;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
        end else begin
            ld_valid <= 1'b0;
            bus_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (op && !misalign) begin
                        state     <= ST_REQ;
                        mem_req   <= 1'b1;
                        mem_we    <= ex_write;
                        mem_be    <= ex_write ? st_be : 4'b1111;
                        mem_wdata <= ex_write ? st_wdata : 32'd0;
                        mem_addr  <= {ex_addr[31:2], 2'b00};
                        offset_q  <= ex_addr[1:0];
                        funct3_q  <= ex_funct3;
                        tcnt      <= 32'd0;
                    end
                end
                ST_REQ: begin
                    if (mem_gnt && (mem_we || mem_rvalid)) begin
                        mem_req <= 1'b0;
                        state   <= ST_DONE;
                        if (!mem_we) begin
                            ld_data  <= ld_ext;
                            ld_valid <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        mem_req  <= 1'b0;
                        bus_err  <= 1'b1;
                        ld_data  <= 32'd0;
                        ld_valid <= ~mem_we;
                        state    <= ST_DONE;
                    end else if (mem_gnt) begin
                        mem_req <= 1'b0;
                        tcnt    <= tcnt + 32'd1;
                        state   <= ST_WAIT_R;
                    end else begin
                        tcnt <= tcnt + 32'd1;
                    end
                end
                ST_WAIT_R: begin
                    if (mem_rvalid) begin
                        ld_data  <= ld_ext;
                        ld_valid <= 1'b1;
                        state    <= ST_DONE;
                    end else if (timeout_hit) begin
                        bus_err  <= 1'b1;
                        ld_data  <= 32'd0;
                        ld_valid <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        tcnt <= tcnt + 32'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
